mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//   Upstream driver for the 8:1 select mux. Steps the mux select through
//   every channel, waits a settle interval on each, samples the single-bit
//   mux output, and packs the samples into one NUM_CH-bit word.
//   Hands the word downstream over a valid/ready handshake.
//   Supports one-shot scans and back-to-back continuous scans.
// PARAMETERS
//   NUM_CH         8   channels scanned; must equal 2**SEL_W
//   SEL_W          3   select width driven to the mux
//   SETTLE_CYCLES  2   wait cycles after each select change before sampling (0..15)
// PORTS
//   clk          in   1        single clock, rising edge
//   rst          in   1        asynchronous, active-high reset
//   start        in   1        begin a scan; honoured only in IDLE
//   continuous   in   1        1: start a new scan after each word is accepted
//   mux_out      in   1        output of the downstream mux
//   select       out  SEL_W    channel select to the mux
//   busy         out  1        high from scan start until word accepted
//   word_valid   out  1        word_data holds a complete scan
//   word_ready   in   1        consumer accepts word when valid&&ready
//   word_data    out  NUM_CH   bit i = mux_out sampled while select==i
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, select=0, busy=0,
//     word_valid=0, word_data=0, settle counter=0. A reset mid-scan
//     discards the partial word.
//   FSM states: IDLE, SETTLE, SAMPLE, HOLD.
//     IDLE: on the edge where start=1: select<=0, busy<=1, word_data<=0,
//       counter<=SETTLE_CYCLES. Go to SETTLE, or to SAMPLE if SETTLE_CYCLES=0.
//     SETTLE: decrement the counter each cycle. Go to SAMPLE on the cycle
//       the counter reaches 1.
//     SAMPLE: exactly one cycle. word_data[select]<=mux_out.
//       If select==NUM_CH-1: word_valid<=1 and go to HOLD.
//       Otherwise: select<=select+1, reload the counter, and go to SETTLE
//       (or stay in SAMPLE if SETTLE_CYCLES=0).
//     HOLD: word_data and select stay stable while word_valid=1.
//       On valid&&ready: word_valid<=0.
//         If continuous=1 at that edge: restart exactly as if IDLE saw start.
//           busy stays 1 and there is no idle bubble.
//         Otherwise: go to IDLE with busy<=0.
//   Timing: each channel takes SETTLE_CYCLES+1 cycles. word_valid rises
//     NUM_CH*(SETTLE_CYCLES+1) edges after the start edge (24 at defaults).
//   Boundary rules:
//     - start while busy is ignored.
//     - word_ready while !word_valid is ignored.
//     - No overrun: a stalled consumer holds the FSM in HOLD; nothing is dropped.
//     - select never exceeds NUM_CH-1. It returns to 0 only on restart or reset.
// CONFIGURATION
//   MUX_SCAN_PARITY_EN
//     Defined: adds output word_parity (out, 1) = ^word_data (even parity).
//       It is registered together with word_valid and is 0 at reset.
//     Undefined: the port and its logic are absent. All other behaviour is
//       identical.
// TESTING
//   1. Wire to the 8:1 mux with in_0..in_7 = 1,0,1,0,1,0,1,0. Pulse start.
//      -> word_valid at edge 24, word_data=8'h55; select visits 0..7 in order.
//   2. Hold word_ready=0 for 10 cycles after word_valid.
//      -> word_data stays 8'h55, busy=1, select=7.
//      Then raise ready -> word_valid=0 and busy=0 on the next edge.
//   3. continuous=1, word_ready=1. -> second word_valid 25 edges after the first.
//      busy is never deasserted. Both words are 8'h55.
//   4. Assert rst at edge 10 of a scan. -> select=0, busy=0, word_valid=0
//      immediately. A fresh start produces a correct word.
//   5. SETTLE_CYCLES=0, all inputs=1. -> word_valid at edge 8, word_data=8'hFF.
//      With MUX_SCAN_PARITY_EN defined, word_parity=0.
//   6. Pulse start at edge 5 of a scan. -> ignored; the scan completes at
//      edge 24 unchanged.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// Handshake and mux-facing signals of mux_scan_sequencer, grouped into one bundle.
// With MUX_SCAN_PARITY_EN defined, the bundle also carries word_parity.
interface mux_scan_sequencer_if #(
   parameter int NUM_CH = 8,
   parameter int SEL_W  = 3
);
   logic              start;
   logic              continuous;
   logic              mux_out;
   logic [SEL_W-1:0]  select;
   logic              busy;
   logic              word_valid;
   logic              word_ready;
   logic [NUM_CH-1:0] word_data;
`ifdef MUX_SCAN_PARITY_EN
   logic              word_parity;
`endif

   // The sequencer side drives the select and word outputs.
   modport master (
      input  start, continuous, mux_out, word_ready,
      output select, busy, word_valid, word_data
`ifdef MUX_SCAN_PARITY_EN
      , output word_parity
`endif
   );

   // The host side issues start/ready and receives the packed word.
   modport slave (
      output start, continuous, mux_out, word_ready,
      input  select, busy, word_valid, word_data
`ifdef MUX_SCAN_PARITY_EN
      , input word_parity
`endif
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Walks the mux select over every channel, samples mux_out after a settle wait, and
// hands the packed word downstream. MUX_SCAN_PARITY_EN adds an even-parity output.
module mux_scan_sequencer #(
   parameter int NUM_CH        = 8,
   parameter int SEL_W         = 3,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   mux_scan_sequencer_if.master  scan_if
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;

   localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
   localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_CH - 1);
   // With no settle wait, every channel is a bare SAMPLE cycle.
   localparam state_t           FIRST_ST  = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [NUM_CH-1:0] data_q, data_d;
   logic              restart;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      data_d  = data_q;
      restart = 1'b0;

      unique case (state_q)
         IDLE: begin
            restart = scan_if.start;
         end
         SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            data_d[sel_q] = scan_if.mux_out;
            if (sel_q == LAST_SEL) begin
               valid_d = 1'b1;
               state_d = HOLD;
            end else begin
               sel_d   = sel_q + SEL_W'(1);
               cnt_d   = SETTLE_LD;
               state_d = FIRST_ST;
            end
         end
         HOLD: begin
            // A stalled consumer parks the FSM here; word and select stay frozen.
            if (valid_q && scan_if.word_ready) begin
               valid_d = 1'b0;
               if (scan_if.continuous) begin
                  restart = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A continuous restart from HOLD is indistinguishable from a start in IDLE.
      if (restart) begin
         sel_d   = '0;
         busy_d  = 1'b1;
         data_d  = '0;
         cnt_d   = SETTLE_LD;
         state_d = FIRST_ST;
      end
   end

   assign scan_if.select     = sel_q;
   assign scan_if.busy       = busy_q;
   assign scan_if.word_valid = valid_q;
   assign scan_if.word_data  = data_q;

`ifdef MUX_SCAN_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = ^data_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign scan_if.word_parity = parity_q;
`endif
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer: one default instance and one with no settle
// wait; expected words are queued at stimulus time and popped by per-instance monitors.
module tb_mux_scan_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_z = 8'h00;

   int checks = 0;
   int errors = 0;
   int sel_bad = 0;
   int busy_drop = 0;
   logic [7:0] qa[$];
   logic [7:0] qz[$];

   always #5 clk = ~clk;

   mux_scan_sequencer_if #(.NUM_CH(8), .SEL_W(3)) ifa ();
   mux_scan_sequencer_if #(.NUM_CH(8), .SEL_W(3)) ifz ();

   assign ifa.mux_out = in_a[ifa.select];
   assign ifz.mux_out = in_z[ifz.select];

   mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .scan_if(ifa));
   mux_scan_sequencer #(.NUM_CH(8), .SEL_W(3), .SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .scan_if(ifz));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitors: pop the expected word whenever a handshake is presented.
   always @(negedge clk) begin
      if (ifa.word_valid && ifa.word_ready) begin
         if (qa.size() == 0) begin
            chk("word_a_unexpected", {24'h0, ifa.word_data}, 32'hFFFF_FFFF);
         end else begin
            logic [7:0] e;
            e = qa.pop_front();
            chk("word_a", {24'h0, ifa.word_data}, {24'h0, e});
`ifdef MUX_SCAN_PARITY_EN
            chk("parity_a", {31'h0, ifa.word_parity}, {31'h0, ^e});
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (ifz.word_valid && ifz.word_ready) begin
         if (qz.size() == 0) begin
            chk("word_z_unexpected", {24'h0, ifz.word_data}, 32'hFFFF_FFFF);
         end else begin
            logic [7:0] e;
            e = qz.pop_front();
            chk("word_z", {24'h0, ifz.word_data}, {24'h0, e});
`ifdef MUX_SCAN_PARITY_EN
            chk("parity_z", {31'h0, ifz.word_parity}, {31'h0, ^e});
`endif
         end
      end
   end

   task automatic pulse_start_a();
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
   endtask

   // Counts edges after the start edge until word_valid; optionally checks the select walk
   // and re-pulses start mid-scan at edge poke_at+1.
   task automatic wait_valid_a(input bit track_sel, input int poke_at, output int n);
      logic [2:0] es;
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (poke_at > 0 && k == poke_at) ifa.start = 1'b1;
         if (poke_at > 0 && k == poke_at + 1) ifa.start = 1'b0;
         if (!ifa.busy) busy_drop++;
         es = (k >= 24) ? 3'd7 : 3'(k / 3);
         if (track_sel && ifa.select !== es) sel_bad++;
         if (ifa.word_valid) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic wait_valid_z(output int n);
      n = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (ifz.word_valid) begin
            n = k;
            break;
         end
      end
   endtask

   initial begin
      int n;
      ifa.start = 1'b0; ifa.continuous = 1'b0; ifa.word_ready = 1'b0;
      ifz.start = 1'b0; ifz.continuous = 1'b0; ifz.word_ready = 1'b0;

      @(negedge clk);
      chk("rst_select", {29'h0, ifa.select}, 32'h0);
      chk("rst_busy", {31'h0, ifa.busy}, 32'h0);
      chk("rst_valid", {31'h0, ifa.word_valid}, 32'h0);
      chk("rst_data", {24'h0, ifa.word_data}, 32'h0);
      chk("rst_z_valid", {31'h0, ifz.word_valid}, 32'h0);
`ifdef MUX_SCAN_PARITY_EN
      chk("rst_parity", {31'h0, ifa.word_parity}, 32'h0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Alternating inputs, single scan, consumer stalled.
      in_a = 8'h55;
      qa.push_back(8'h55);
      sel_bad = 0; busy_drop = 0;
      pulse_start_a();
      wait_valid_a(1'b1, 0, n);
      chk("t1_valid_edge", n, 24);
      chk("t1_select_walk", sel_bad, 0);
      chk("t1_busy_hold", busy_drop, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("t2_stall_data", {24'h0, ifa.word_data}, 32'h55);
      chk("t2_stall_busy", {31'h0, ifa.busy}, 32'h1);
      chk("t2_stall_select", {29'h0, ifa.select}, 32'h7);
      chk("t2_stall_valid", {31'h0, ifa.word_valid}, 32'h1);
      ifa.word_ready = 1'b1;
      @(posedge clk); #1;
      chk("t2_accept_valid", {31'h0, ifa.word_valid}, 32'h0);
      chk("t2_accept_busy", {31'h0, ifa.busy}, 32'h0);

      // Continuous back-to-back scans.
      ifa.continuous = 1'b1;
      qa.push_back(8'h55);
      qa.push_back(8'h55);
      busy_drop = 0;
      pulse_start_a();
      wait_valid_a(1'b0, 0, n);
      chk("t3_first_edge", n, 24);
      wait_valid_a(1'b0, 0, n);
      chk("t3_second_gap", n, 25);
      chk("t3_busy_never_low", busy_drop, 0);
      ifa.continuous = 1'b0;
      @(posedge clk); #1;
      chk("t3_end_busy", {31'h0, ifa.busy}, 32'h0);

      // Reset in the middle of a scan, then a clean scan.
      in_a = 8'hCA;
      pulse_start_a();
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t4_rst_select", {29'h0, ifa.select}, 32'h0);
      chk("t4_rst_busy", {31'h0, ifa.busy}, 32'h0);
      chk("t4_rst_valid", {31'h0, ifa.word_valid}, 32'h0);
      chk("t4_rst_data", {24'h0, ifa.word_data}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      qa.push_back(8'hCA);
      sel_bad = 0;
      pulse_start_a();
      wait_valid_a(1'b1, 0, n);
      chk("t4_valid_edge", n, 24);
      chk("t4_select_walk", sel_bad, 0);
      @(posedge clk); #1;
      chk("t4_end_busy", {31'h0, ifa.busy}, 32'h0);

      // Start re-pulsed mid-scan must not disturb the scan.
      ifa.word_ready = 1'b0;
      in_a = 8'h3C;
      qa.push_back(8'h3C);
      sel_bad = 0;
      pulse_start_a();
      wait_valid_a(1'b1, 4, n);
      chk("t6_valid_edge", n, 24);
      chk("t6_select_walk", sel_bad, 0);
      ifa.word_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_end_busy", {31'h0, ifa.busy}, 32'h0);
      ifa.word_ready = 1'b0;

      // No settle wait: all-ones, then a single one (odd parity).
      ifz.word_ready = 1'b1;
      in_z = 8'hFF;
      qz.push_back(8'hFF);
      ifz.start = 1'b1;
      @(posedge clk); #1;
      ifz.start = 1'b0;
      wait_valid_z(n);
      chk("t5_valid_edge", n, 8);
      @(posedge clk); #1;
      chk("t5_end_busy", {31'h0, ifz.busy}, 32'h0);
      in_z = 8'h01;
      qz.push_back(8'h01);
      ifz.start = 1'b1;
      @(posedge clk); #1;
      ifz.start = 1'b0;
      wait_valid_z(n);
      chk("t5b_valid_edge", n, 8);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      #1;
      chk("qa_drained", qa.size(), 0);
      chk("qz_drained", qz.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
